// File: rtl/axi_lsu_pkg.sv
// Shared types for the AXI-Lite load/store master.
// Access sizes, bus response codes and FSM states.
package axi_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD,
    S_RD_DATA,
    S_RSP
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction.
// Also flags misaligned or illegal-size accesses.
module lsu_align
  import axi_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] ld_data,
  output logic        bad
);

  logic [31:0] sh;

  // Lane replication, strobes, load shift and extension
  always_comb begin
    sh      = rdata >> {off, 3'b000};
    st_data = wdata;
    st_strb = 4'hF;
    ld_data = rdata;
    bad     = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << off;
        ld_data = {{24{sh[7] & ~uns}}, sh[7:0]};
      end
      (size == SZ_HALF): begin
        st_data = {2{wdata[15:0]}};
        st_strb = 4'b0011 << off;
        ld_data = {{16{sh[15] & ~uns}}, sh[15:0]};
        bad     = off[0];
      end
      (size == SZ_WORD): begin
        bad = (off != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_lsu_master.sv
// AXI4-Lite master for single core loads/stores.
// One transaction outstanding; all outputs registered.
module axi_lsu_master
  import axi_lsu_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [AXI_AWIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0] AXI_WDATA,
  output logic [3:0]            AXI_WSTRB,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,
  input  logic [1:0]            AXI_BRESP,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  if (AXI_DWIDTH != 32) begin : g_dw_check
    $error("axi_lsu_master: AXI_DWIDTH must be 32");
  end

  state_e      st;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_uns;
  logic        aw_done;
  logic        w_done;
  logic [1:0]  a_size;
  logic [1:0]  a_off;
  logic        a_uns;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] ld_data;
  logic        bad;
  logic [31:0] wa;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_fin;
  logic        w_fin;

  assign wa     = {req_addr[31:2], 2'b00};
  assign a_size = (st == S_IDLE) ? req_size : lat_size;
  assign a_off  = (st == S_IDLE) ? req_addr[1:0] : lat_off;
  assign a_uns  = (st == S_IDLE) ? req_unsigned : lat_uns;
  assign aw_hs  = AXI_AWVALID & AXI_AWREADY;
  assign w_hs   = AXI_WVALID & AXI_WREADY;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  lsu_align u_align (
    .size    (a_size),
    .off     (a_off),
    .uns     (a_uns),
    .wdata   (req_wdata),
    .rdata   (AXI_RDATA),
    .st_data (st_data),
    .st_strb (st_strb),
    .ld_data (ld_data),
    .bad     (bad)
  );

  // Transaction sequencing and every registered output
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      st          <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      AXI_AWADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARADDR  <= '0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      lat_size    <= '0;
      lat_off     <= '0;
      lat_uns     <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          lat_size  <= req_size;
          lat_off   <= req_addr[1:0];
          lat_uns   <= req_unsigned;
          if (bad) begin
            st        <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (req_write) begin
            st          <= S_WR;
            AXI_AWVALID <= 1'b1;
            AXI_WVALID  <= 1'b1;
            AXI_BREADY  <= 1'b1;
            AXI_AWADDR  <= wa[AXI_AWIDTH-1:0];
            AXI_WDATA   <= st_data;
            AXI_WSTRB   <= st_strb;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
          end else begin
            st          <= S_RD;
            AXI_ARVALID <= 1'b1;
            AXI_RREADY  <= 1'b1;
            AXI_ARADDR  <= wa[AXI_AWIDTH-1:0];
          end
        end
        S_WR: begin
          if (aw_hs) begin
            AXI_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            AXI_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            if (AXI_BVALID) begin
              st         <= S_RSP;
              AXI_BREADY <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_err    <= (AXI_BRESP != OKAY);
              rsp_rdata  <= '0;
            end else begin
              st <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: if (AXI_BVALID) begin
          st         <= S_RSP;
          AXI_BREADY <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_err    <= (AXI_BRESP != OKAY);
          rsp_rdata  <= '0;
        end
        S_RD: if (AXI_ARREADY) begin
          AXI_ARVALID <= 1'b0;
          if (AXI_RVALID) begin
            st         <= S_RSP;
            AXI_RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= (AXI_RRESP != OKAY);
            rsp_rdata  <= (AXI_RRESP != OKAY) ? '0 : ld_data;
          end else begin
            st <= S_RD_DATA;
          end
        end
        S_RD_DATA: if (AXI_RVALID) begin
          st         <= S_RSP;
          AXI_RREADY <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_err    <= (AXI_RRESP != OKAY);
          rsp_rdata  <= (AXI_RRESP != OKAY) ? '0 : ld_data;
        end
        S_RSP: begin
          st        <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lsu_master.sv
// Scoreboard bench for axi_lsu_master.
// Directed loads/stores against a delay-configurable slave.
module tb_axi_lsu_master;
  import axi_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axi_lsu_master dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .AXI_AWADDR(AWADDR), .AXI_AWVALID(AWVALID),
    .AXI_AWREADY(AWREADY), .AXI_WDATA(WDATA),
    .AXI_WSTRB(WSTRB), .AXI_WVALID(WVALID),
    .AXI_WREADY(WREADY), .AXI_BRESP(BRESP),
    .AXI_BVALID(BVALID), .AXI_BREADY(BREADY),
    .AXI_ARADDR(ARADDR), .AXI_ARVALID(ARVALID),
    .AXI_ARREADY(ARREADY), .AXI_RDATA(RDATA),
    .AXI_RRESP(RRESP), .AXI_RVALID(RVALID),
    .AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } wexp_t;

  rsp_t  rq[$];
  wexp_t wq[$];
  rsp_t  mr;
  wexp_t mw;

  // slave configuration
  int aw_dly = 1, w_dly = 1, b_dly = 0;
  int ar_dly = 1, r_dly = 0;
  logic [1:0] bresp_cfg = OKAY;
  logic [1:0] rresp_cfg = OKAY;

  logic [31:0] mem [0:15];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic aw_got, w_got, ar_got;
  logic aw_hs, w_hs, aw_soon, w_soon;
  logic ar_hs, ar_rise;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign ar_hs   = ARVALID & ARREADY;
  assign aw_soon = aw_got | aw_hs |
                   (AWVALID & ~AWREADY & (aw_wait + 1 >= aw_dly));
  assign w_soon  = w_got | w_hs |
                   (WVALID & ~WREADY & (w_wait + 1 >= w_dly));
  assign ar_rise = ARVALID & ~ARREADY & ~ar_got &
                   (ar_wait + 1 >= ar_dly);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AWREADY <= 0; WREADY <= 0; BVALID <= 0;
      ARREADY <= 0; RVALID <= 0;
      BRESP <= '0; RRESP <= '0; RDATA <= '0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      ar_wait <= 0; r_wait <= 0;
    end else begin
      if (aw_hs) begin
        AWREADY <= 0; aw_got <= 1; aw_wait <= 0;
      end else if (AWVALID && !aw_got) begin
        aw_wait <= aw_wait + 1;
        if (aw_wait + 1 >= aw_dly) AWREADY <= 1;
      end
      if (w_hs) begin
        WREADY <= 0; w_got <= 1; w_wait <= 0;
        for (int b = 0; b < 4; b++)
          if (WSTRB[b])
            mem[AWADDR[5:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end else if (WVALID && !w_got) begin
        w_wait <= w_wait + 1;
        if (w_wait + 1 >= w_dly) WREADY <= 1;
      end
      if (BVALID && BREADY) begin
        BVALID <= 0; aw_got <= 0; w_got <= 0; b_wait <= 0;
      end else if (!BVALID) begin
        if (b_dly == 0) begin
          if (aw_soon && w_soon) begin
            BVALID <= 1; BRESP <= bresp_cfg;
          end
        end else if ((aw_got | aw_hs) && (w_got | w_hs)) begin
          b_wait <= b_wait + 1;
          if (b_wait + 1 >= b_dly) begin
            BVALID <= 1; BRESP <= bresp_cfg;
          end
        end
      end
      if (ar_hs) begin
        ARREADY <= 0; ar_got <= 1; ar_wait <= 0;
      end else if (ARVALID && !ar_got) begin
        ar_wait <= ar_wait + 1;
        if (ar_wait + 1 >= ar_dly) ARREADY <= 1;
      end
      if (RVALID && RREADY) begin
        RVALID <= 0; ar_got <= 0; r_wait <= 0;
      end else if (!RVALID) begin
        if (r_dly == 0) begin
          if (ar_rise) begin
            RVALID <= 1; RRESP <= rresp_cfg;
            RDATA <= mem[ARADDR[5:2]];
          end
        end else if (ar_got || ar_hs) begin
          r_wait <= r_wait + 1;
          if (r_wait + 1 >= r_dly) begin
            RVALID <= 1; RRESP <= rresp_cfg;
            RDATA <= mem[ARADDR[5:2]];
          end
        end
      end
    end
  end

  int act_n = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0;

  // monitor: pops expectations as the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (AWVALID || ARVALID) act_n++;
      if (aw_hs) aw_n++;
      if (ar_hs) ar_n++;
      if (BVALID && BREADY) b_n++;
      if (w_hs) begin
        w_n++;
        if (wq.size() == 0) fail("w_stray");
        else begin
          mw = wq.pop_front();
          chk("wdata", WDATA, mw.d);
          chk("wstrb", {28'd0, WSTRB}, {28'd0, mw.s});
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) fail("rsp_stray");
        else begin
          mr = rq.pop_front();
          chk("rdata", rsp_rdata, mr.rdata);
          chk("err", {31'd0, rsp_err}, {31'd0, mr.err});
          chk("latency", cyc - mr.acc, mr.lat);
        end
      end
    end
  end

  task automatic issue(input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0] sz,
                       input logic u,
                       input logic [31:0] erd,
                       input logic eerr,
                       input int lat,
                       input logic bus,
                       input logic [31:0] ewd,
                       input logic [3:0] es);
    int k;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d;
    req_size = sz; req_unsigned = u; req_valid = 1;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 0;
      return;
    end
    rq.push_back('{erd, eerr, lat, cyc});
    if (wr && bus) wq.push_back('{ewd, es});
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (rq.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (rq.size() != 0) begin
      fail("rsp_timeout");
      rq.delete();
      wq.delete();
    end
  endtask

  int a0, w0, b0, act0, k;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_valids", {28'd0, AWVALID, WVALID,
        ARVALID, BREADY | RREADY}, 32'd0);
    chk("rst_wstrb", {28'd0, WSTRB}, 32'd0);
    chk("rst_awaddr", AWADDR, 32'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    issue(1, 32'h10, 32'hDEADBEEF, 2'd2, 0,
          32'h0, 0, 3, 1, 32'hDEADBEEF, 4'hF);
    issue(0, 32'h10, 0, 2'd2, 0,
          32'hDEADBEEF, 0, 3, 0, 0, 0);
    issue(1, 32'h13, 32'h80, 2'd0, 0,
          32'h0, 0, 3, 1, 32'h80808080, 4'b1000);
    issue(0, 32'h13, 0, 2'd0, 0,
          32'hFFFFFF80, 0, 3, 0, 0, 0);
    issue(0, 32'h13, 0, 2'd0, 1,
          32'h00000080, 0, 3, 0, 0, 0);
    issue(1, 32'h12, 32'h8001, 2'd1, 0,
          32'h0, 0, 3, 1, 32'h80018001, 4'b1100);
    issue(0, 32'h12, 0, 2'd1, 0,
          32'hFFFF8001, 0, 3, 0, 0, 0);
    issue(0, 32'h12, 0, 2'd1, 1,
          32'h00008001, 0, 3, 0, 0, 0);
    issue(0, 32'h10, 0, 2'd0, 1,
          32'h000000EF, 0, 3, 0, 0, 0);
    issue(0, 32'h11, 0, 2'd0, 0,
          32'hFFFFFFBE, 0, 3, 0, 0, 0);
    issue(0, 32'h10, 0, 2'd2, 0,
          32'h8001BEEF, 0, 3, 0, 0, 0);

    act0 = act_n;
    issue(0, 32'h11, 0, 2'd2, 0, 32'h0, 1, 1, 0, 0, 0);
    issue(1, 32'h03, 32'h1234, 2'd1, 0,
          32'h0, 1, 1, 0, 0, 0);
    issue(1, 32'h20, 32'h1234, 2'd3, 0,
          32'h0, 1, 1, 0, 0, 0);
    chk("no_axi_on_err", act_n, act0);

    aw_dly = 1; w_dly = 4; b_dly = 2;
    a0 = aw_n; w0 = w_n; b0 = b_n;
    issue(1, 32'h20, 32'h12345678, 2'd2, 0,
          32'h0, 0, 8, 1, 32'h12345678, 4'hF);
    chk("aw_once", aw_n - a0, 1);
    chk("w_once", w_n - w0, 1);
    chk("b_once", b_n - b0, 1);
    aw_dly = 1; w_dly = 1; b_dly = 0;

    bresp_cfg = SLVERR;
    issue(1, 32'h24, 32'h0BAD0BAD, 2'd2, 0,
          32'h0, 1, 3, 1, 32'h0BAD0BAD, 4'hF);
    bresp_cfg = OKAY;
    rresp_cfg = SLVERR;
    issue(0, 32'h10, 0, 2'd2, 0, 32'h0, 1, 3, 0, 0, 0);
    rresp_cfg = OKAY;

    ar_dly = 2; r_dly = 3;
    issue(0, 32'h20, 0, 2'd2, 0,
          32'h12345678, 0, 7, 0, 0, 0);
    ar_dly = 1; r_dly = 0;

    ar_dly = 50;
    @(negedge clk);
    req_write = 0; req_addr = 32'h10; req_size = 2'd2;
    req_unsigned = 0; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!ARVALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("arvalid_before_rst", {31'd0, ARVALID}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_arvalid_async", {31'd0, ARVALID}, 32'd0);
    chk("rst_rready_async", {31'd0, RREADY}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    ar_dly = 1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    issue(0, 32'h20, 0, 2'd2, 0,
          32'h12345678, 0, 3, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
